fma16_wb: RTL
=============

# fma16_wb

Result writeback buffer for the `fma16` datapath. It captures each `{result, flags}` pair that `fma16` produces, together with a caller-supplied operation tag, in a small FIFO. It drains that FIFO to the consumer over a valid/ready handshake. It also maintains the architectural sticky exception register (`fflags`) by OR-accumulating the flags of every accepted result. It sits directly downstream of `fma16` and is the first clocked element after that combinational core.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `TAGW`, 4: width of the operation tag carried alongside each result.

Ports:
- `clk` — in — 1 — single clock; all state updates on its rising edge.
- `reset_n` — in — 1 — synchronous, active-low reset.
- `in_valid` — in — 1 — `fma16` output is a result to be written back this cycle.
- `in_ready` — out — 1 — buffer can accept this cycle.
- `in_result` — in — 16 — `fma16.result`.
- `in_flags` — in — 4 — `fma16.flags`: [3]=NV, [2]=OF, [1]=UF, [0]=NX.
- `in_tag` — in — TAGW — operation identifier from the issuing side.
- `out_valid` — out — 1 — head entry present.
- `out_ready` — in — 1 — consumer takes head this cycle.
- `out_result` — out — 16 — head result.
- `out_flags` — out — 4 — head per-op flags.
- `out_tag` — out — TAGW — head tag.
- `fflags` — out — 4 — sticky accumulated flags, same bit order as `in_flags`.
- `fflags_clr` — in — 1 — clear `fflags` and `drop_err`.
- `drop_err` — out — 1 — sticky; a result was offered while `in_ready`=0.
- `count` — out — $clog2(DEPTH)+1 — entries currently held.

## Operation
- **Push** = `in_valid & in_ready`. Write `{in_result, in_flags, in_tag}` at `wr_ptr`, then advance `wr_ptr`.
- **Pop** = `out_valid & out_ready`. Advance `rd_ptr`.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. `count` is tracked separately: +1 on push only, -1 on pop only, unchanged on push and pop together.
- `in_ready` = (`count` != DEPTH). It depends only on registered state, never on `out_ready`, so there is no pass-through when full.
- `out_valid` = (`count` != 0).
- `out_result`, `out_flags` and `out_tag` always read storage at `rd_ptr`, including when `out_valid`=0.
- **fflags update:** next = (`fflags_clr` ? 0 : `fflags`) | (push ? `in_flags` : 0). Accumulation happens at acceptance, not at pop. A clear and a push in the same cycle leave exactly the pushed op's flags.
- **drop_err update:** set when `in_valid & ~in_ready`; cleared by `fflags_clr`. If both happen in the same cycle, set wins. A dropped result does not touch storage, pointers or `fflags`.
- **Empty:** push and pop together is impossible, since pop requires `out_valid`. A push makes the entry visible the next cycle.
- **Full:** pop only, which frees a slot; `in_ready` rises the next cycle.
- Storage contents are never modified except by a push.

## Timing
- **Reset** (`reset_n`=0 at a rising edge): pointers = 0, `count` = 0, `fflags` = 0, `drop_err` = 0, and all storage entries = 0. After reset, `in_ready`=1, `out_valid`=0 and `out_result`/`out_flags`/`out_tag`=0.
- Reset overrides every other input in the same cycle.
- Reset mid-operation discards all held entries and the accumulated flags, with no partial drain.
- **Latency:** push in cycle N → `out_valid`=1 with that data in cycle N+1, when the FIFO was empty.
- **Throughput:** one push and one pop per cycle sustained, when 0 < `count` < DEPTH.
- `fflags` reflects a push in the cycle after acceptance.
- The `fma16` inputs are combinational; the producer must hold `in_*` stable while `in_valid`=1 and `in_ready`=0 if it wants retry semantics. This block does not hold them.
- Entries pop in strict FIFO order; tags are returned unmodified.

## Test plan
- **Reset then single op.** Push result=0x4000 (1.0+1.0), flags=0x0, tag=0x3.
  - Cycle+1: `out_valid`=1, `out_result`=0x4000, `out_tag`=0x3, `fflags`=0x0, `count`=1.
- **Fill with out_ready=0.** Push DEPTH=4 entries, tags 0–3.
  - `in_ready`=0 after the 4th push; `count`=4.
  - A 5th `in_valid` sets `drop_err`=1; `count` and `fflags` are unchanged.
- **Drain with wrap.** From full, hold `out_ready`=1 while pushing tags 4–7 each cycle as slots free.
  - Outputs appear in order tags 0,1,…,7.
  - `wr_ptr`/`rd_ptr` wrap without loss.
- **Sticky flags.** Push flags 0x1, then 0x4, then 0x0.
  - `fflags` goes 0x1 → 0x5 → 0x5.
  - `out_flags` per entry are 0x1, 0x4, 0x0.
- **Clear collision.** With `fflags`=0x5, assert `fflags_clr` in the same cycle as a push with flags 0x8.
  - Next cycle `fflags`=0x8 and `drop_err`=0.
- **Reset mid-stream.** With `count`=3 and `fflags`=0x3, assert `reset_n`=0 for one cycle.
  - Next cycle `count`=0, `out_valid`=0, `fflags`=0 and `out_result`=0x0000.

Source files
------------

// File: rtl/fma16_wb.sv
// Writeback buffer for fma16: small FIFO of {result, flags, tag} with a
// sticky fflags register and a sticky drop error.
module fma16_wb #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_result,
    input  logic [3:0]               in_flags,
    input  logic [TAGW-1:0]          in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_result,
    output logic [3:0]               out_flags,
    output logic [TAGW-1:0]          out_tag,
    output logic [3:0]               fflags,
    input  logic                     fflags_clr,
    output logic                     drop_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 16 + 4 + TAGW;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Ready/valid come only from registered count, so a full buffer never
    // accepts on the strength of a same-cycle pop.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign {out_result, out_flags, out_tag} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fflags   <= '0;
            drop_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_result, in_flags, in_tag};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // A clear together with a push keeps only the pushed op's flags.
            fflags   <= (fflags_clr ? 4'h0 : fflags) | (push ? in_flags : 4'h0);
            drop_err <= (in_valid & ~in_ready) | (drop_err & ~fflags_clr);
        end
    end

endmodule
